// File: rtl/superh16_phys_freelist_pkg.sv
// Shared constants, types and circular-pointer helpers for the physical register free list.
package superh16_phys_freelist_pkg;

    localparam int NUM_PHYS       = 384;
    localparam int NUM_ARCH       = 32;
    localparam int ISSUE_WIDTH    = 12;
    localparam int RETIRE_WIDTH   = 12;
    localparam int ALLOC_W        = ISSUE_WIDTH;
    localparam int FREE_W         = RETIRE_WIDTH;
    localparam int PHYS_REG_BITS  = $clog2(NUM_PHYS);
    localparam int FREELIST_DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int FL_PTR_BITS    = $clog2(FREELIST_DEPTH);
    localparam int FL_CNT_BITS    = $clog2(FREELIST_DEPTH + 1);
    localparam int LANE_CNT_BITS  = $clog2(((ALLOC_W > FREE_W) ? ALLOC_W : FREE_W) + 1);

    typedef logic [PHYS_REG_BITS-1:0] phys_tag_t;
    typedef logic [FL_PTR_BITS-1:0]   fl_ptr_t;
    typedef logic [FL_CNT_BITS-1:0]   fl_cnt_t;
    typedef logic [LANE_CNT_BITS-1:0] lane_cnt_t;
    typedef logic [FL_PTR_BITS:0]     fl_sum_t;

    // Depth is not a power of two, so wrap is an explicit compare-and-subtract.
    function automatic fl_ptr_t ptr_add(fl_ptr_t p, lane_cnt_t n);
        fl_sum_t s;
        s = fl_sum_t'(p) + fl_sum_t'(n);
        if (s >= fl_sum_t'(FREELIST_DEPTH))
            s = s - fl_sum_t'(FREELIST_DEPTH);
        return fl_ptr_t'(s);
    endfunction

    function automatic fl_ptr_t ptr_dist(fl_ptr_t a, fl_ptr_t b);
        fl_sum_t s;
        if (a >= b)
            s = fl_sum_t'(a) - fl_sum_t'(b);
        else
            s = fl_sum_t'(a) + fl_sum_t'(FREELIST_DEPTH) - fl_sum_t'(b);
        return fl_ptr_t'(s);
    endfunction

endpackage

// File: rtl/superh16_phys_freelist_if.sv
// Rename/commit-side bundle of the free list. dup_err exists only with FREELIST_DUP_CHECK_EN.
interface superh16_phys_freelist_if;
    import superh16_phys_freelist_pkg::*;

    logic [ALLOC_W-1:0]              alloc_req;
    logic                            alloc_ready;
    phys_tag_t [ALLOC_W-1:0]         alloc_tag;
    logic [FREE_W-1:0]               commit_valid;
    logic [FREE_W-1:0]               commit_has_dst;
    phys_tag_t [FREE_W-1:0]          commit_old_tag;
    logic                            flush;
    fl_cnt_t                         free_count;
`ifdef FREELIST_DUP_CHECK_EN
    logic                            dup_err;
`endif

    modport master (
`ifdef FREELIST_DUP_CHECK_EN
        input  dup_err,
`endif
        output alloc_req, commit_valid, commit_has_dst, commit_old_tag, flush,
        input  alloc_ready, alloc_tag, free_count
    );

    modport slave (
`ifdef FREELIST_DUP_CHECK_EN
        output dup_err,
`endif
        input  alloc_req, commit_valid, commit_has_dst, commit_old_tag, flush,
        output alloc_ready, alloc_tag, free_count
    );

endinterface

// File: rtl/superh16_phys_freelist_lane_compact.sv
// Per-lane exclusive prefix popcount of a lane mask, plus the total count.
module superh16_phys_freelist_lane_compact #(
    parameter int W  = 12,
    parameter int OB = 4
) (
    input  logic [W-1:0]          mask,
    output logic [W-1:0][OB-1:0]  offset,
    output logic [OB-1:0]         total
);

    logic [OB-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < W; i++) begin
            offset[i] = acc;
            acc       = acc + OB'(mask[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/superh16_phys_freelist.sv
// Physical register free list with speculative/committed heads; flush rewinds the spec head.
// Optional FREELIST_DUP_CHECK_EN adds an is_free shadow vector and a registered dup_err pulse.
module superh16_phys_freelist
    import superh16_phys_freelist_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    superh16_phys_freelist_if.slave   fl_if
);

    phys_tag_t fl_q [FREELIST_DEPTH];
    phys_tag_t fl_d [FREELIST_DEPTH];
    fl_ptr_t   spec_head_q, spec_head_d;
    fl_ptr_t   commit_head_q, commit_head_d;
    fl_ptr_t   tail_q, tail_d;
    fl_cnt_t   spec_count_q, spec_count_d;
    fl_cnt_t   commit_count_q, commit_count_d;

    lane_cnt_t [ALLOC_W-1:0] a_off;
    lane_cnt_t [FREE_W-1:0]  f_off;
    lane_cnt_t               a_total, f_total;
    lane_cnt_t               n_a, n_f;
    logic [FREE_W-1:0]       rel_mask;
    logic                    alloc_ready;
    phys_tag_t [ALLOC_W-1:0] alloc_tag;

    superh16_phys_freelist_lane_compact #(.W(ALLOC_W), .OB(LANE_CNT_BITS)) u_alloc_compact (
        .mask   (fl_if.alloc_req),
        .offset (a_off),
        .total  (a_total)
    );

    superh16_phys_freelist_lane_compact #(.W(FREE_W), .OB(LANE_CNT_BITS)) u_free_compact (
        .mask   (rel_mask),
        .offset (f_off),
        .total  (f_total)
    );

    assign rel_mask    = fl_if.commit_valid & fl_if.commit_has_dst;
    assign alloc_ready = (spec_count_q >= fl_cnt_t'(ALLOC_W)) && !fl_if.flush;
    assign n_a         = alloc_ready ? a_total : '0;
    assign n_f         = f_total;

    always_comb begin
        for (int i = 0; i < ALLOC_W; i++)
            alloc_tag[i] = fl_q[ptr_add(spec_head_q, a_off[i])];
    end

    assign fl_if.alloc_ready = alloc_ready;
    assign fl_if.alloc_tag   = alloc_tag;
    assign fl_if.free_count  = spec_count_q;

    always_comb begin
        fl_d = fl_q;
        for (int i = 0; i < FREE_W; i++)
            if (rel_mask[i])
                fl_d[ptr_add(tail_q, f_off[i])] = fl_if.commit_old_tag[i];
        tail_d         = ptr_add(tail_q, n_f);
        commit_head_d  = ptr_add(commit_head_q, n_f);
        // Each renamed commit frees one tag and consumes one, so the committed count holds.
        commit_count_d = commit_count_q;
        if (fl_if.flush) begin
            spec_head_d  = commit_head_d;
            spec_count_d = commit_count_q;
        end else begin
            spec_head_d  = ptr_add(spec_head_q, n_a);
            spec_count_d = spec_count_q - fl_cnt_t'(n_a) + fl_cnt_t'(n_f);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FREELIST_DEPTH; i++)
                fl_q[i] <= phys_tag_t'(NUM_ARCH + i);
            spec_head_q    <= '0;
            commit_head_q  <= '0;
            tail_q         <= '0;
            spec_count_q   <= fl_cnt_t'(FREELIST_DEPTH);
            commit_count_q <= fl_cnt_t'(FREELIST_DEPTH);
        end else begin
            fl_q           <= fl_d;
            spec_head_q    <= spec_head_d;
            commit_head_q  <= commit_head_d;
            tail_q         <= tail_d;
            spec_count_q   <= spec_count_d;
            commit_count_q <= commit_count_d;
        end
    end

`ifdef FREELIST_DUP_CHECK_EN
    logic [NUM_PHYS-1:0] is_free_q, is_free_d;
    logic                dup_err_q, dup_err_d;
    fl_cnt_t             rewind_cnt;

    always_comb begin
        is_free_d  = is_free_q;
        dup_err_d  = 1'b0;
        rewind_cnt = commit_count_q - spec_count_q - fl_cnt_t'(n_f);
        for (int i = 0; i < ALLOC_W; i++)
            if (alloc_ready && fl_if.alloc_req[i])
                is_free_d[alloc_tag[i]] = 1'b0;
        for (int i = 0; i < FREE_W; i++) begin
            if (rel_mask[i]) begin
                if (is_free_q[fl_if.commit_old_tag[i]])
                    dup_err_d = 1'b1;
                for (int j = 0; j < i; j++)
                    if (rel_mask[j] && fl_if.commit_old_tag[j] == fl_if.commit_old_tag[i])
                        dup_err_d = 1'b1;
                is_free_d[fl_if.commit_old_tag[i]] = 1'b1;
            end
        end
        // Tags between the rewound head and the old spec head become free again.
        if (fl_if.flush)
            for (int j = 0; j < FREELIST_DEPTH; j++)
                if (fl_cnt_t'(ptr_dist(fl_ptr_t'(j), commit_head_d)) < rewind_cnt)
                    is_free_d[fl_q[j]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_free_q <= {{FREELIST_DEPTH{1'b1}}, {NUM_ARCH{1'b0}}};
            dup_err_q <= 1'b0;
        end else begin
            is_free_q <= is_free_d;
            dup_err_q <= dup_err_d;
        end
    end

    assign fl_if.dup_err = dup_err_q;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (spec_count_q <= commit_count_q);
            assert (commit_count_q <= fl_cnt_t'(FREELIST_DEPTH));
            assert ((32'(spec_count_q) + 32'(n_f)) <= (32'(commit_count_q) + 32'(n_a)));
        end
    end
`endif

endmodule

// File: tb/tb_superh16_phys_freelist.sv
// Randomized bench for superh16_phys_freelist against a queue-based free-list model.
module tb_superh16_phys_freelist;
    import superh16_phys_freelist_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    superh16_phys_freelist_if fl_if ();

    superh16_phys_freelist dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fl_if (fl_if.slave)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Model: fq holds the committed free order (oldest first); the first
    // 'inflight' entries have been handed out speculatively.
    int fq[$];
    int inflight;

    logic [ALLOC_W-1:0] s_req;
    logic [FREE_W-1:0]  s_cv, s_cd;
    int                 s_tag [FREE_W];
    logic               s_flush;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_stim();
        s_req = '0; s_cv = '0; s_cd = '0; s_flush = 1'b0;
        for (int i = 0; i < FREE_W; i++) s_tag[i] = 0;
    endtask

    task automatic model_reset();
        fq.delete();
        for (int i = 0; i < FREELIST_DEPTH; i++) fq.push_back(NUM_ARCH + i);
        inflight = 0;
    endtask

    task automatic do_reset();
        idle_stim();
        fl_if.alloc_req = '0; fl_if.commit_valid = '0; fl_if.commit_has_dst = '0;
        fl_if.commit_old_tag = '0; fl_if.flush = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
    endtask

    // Called #1 after a posedge: drive stimulus and let outputs settle.
    task automatic apply();
        fl_if.alloc_req      = s_req;
        fl_if.commit_valid   = s_cv;
        fl_if.commit_has_dst = s_cd;
        fl_if.flush          = s_flush;
        for (int i = 0; i < FREE_W; i++) fl_if.commit_old_tag[i] = phys_tag_t'(s_tag[i]);
        #2;
    endtask

    task automatic model_step();
        int  k;
        logic rdy;
        rdy = ((FREELIST_DEPTH - inflight) >= ALLOC_W) && !s_flush;
        chk("alloc_ready", 32'(fl_if.alloc_ready), 32'(rdy));
        chk("free_count", 32'(fl_if.free_count), FREELIST_DEPTH - inflight);
        k = 0;
        if (rdy) begin
            for (int i = 0; i < ALLOC_W; i++)
                if (s_req[i]) begin
                    chk("alloc_tag", 32'(fl_if.alloc_tag[i]), fq[inflight + k]);
                    k++;
                end
            inflight += k;
        end
        for (int i = 0; i < FREE_W; i++)
            if (s_cv[i] && s_cd[i]) begin
                void'(fq.pop_front());
                fq.push_back(s_tag[i]);
                inflight--;
            end
        if (s_flush) inflight = 0;
        @(posedge clk); #1;
    endtask

    task automatic run_step();
        apply();
        model_step();
    endtask

    initial begin
        int budget, phase, cprob;

        // Reset state and a full-width allocation.
        do_reset();
        s_req = '1;
        apply();
        chk("rst_free_count", 32'(fl_if.free_count), FREELIST_DEPTH);
        chk("rst_alloc_ready", 32'(fl_if.alloc_ready), 1);
        for (int i = 0; i < ALLOC_W; i++) chk("rst_alloc_tag", 32'(fl_if.alloc_tag[i]), NUM_ARCH + i);
        model_step();
        apply();
        chk("t1_free_count", 32'(fl_if.free_count), 340);
        for (int i = 0; i < ALLOC_W; i++) chk("t1_alloc_tag", 32'(fl_if.alloc_tag[i]), 44 + i);
        model_step();

        // Sparse request mask is compacted.
        do_reset();
        s_req = 12'b101;
        apply();
        chk("t2_lane0", 32'(fl_if.alloc_tag[0]), 32);
        chk("t2_lane2", 32'(fl_if.alloc_tag[2]), 33);
        model_step();
        idle_stim();
        apply();
        chk("t2_free_count", 32'(fl_if.free_count), 350);
        model_step();

        // Drain below one full group, then one release re-opens rename.
        do_reset();
        s_req = '1;
        for (int c = 0; c < 28; c++) run_step();
        s_req = 12'h01F;
        run_step();
        s_req = '1; s_cv = 12'h001; s_cd = 12'h001; s_tag[0] = 5;
        apply();
        chk("t3_ready_low", 32'(fl_if.alloc_ready), 0);
        chk("t3_free_count", 32'(fl_if.free_count), 11);
        model_step();
        idle_stim();
        apply();
        chk("t3_free_count_after", 32'(fl_if.free_count), 12);
        chk("t3_ready_high", 32'(fl_if.alloc_ready), 1);
        model_step();

        // Flush while six renamed instructions commit.
        do_reset();
        s_req = '1;
        run_step();
        run_step();
        s_cv = 12'h03F; s_cd = 12'h03F; s_flush = 1'b1;
        for (int i = 0; i < 6; i++) s_tag[i] = i + 1;
        apply();
        chk("t5_ready_flush", 32'(fl_if.alloc_ready), 0);
        model_step();
        idle_stim();
        s_req = '1;
        apply();
        chk("t5_free_count", 32'(fl_if.free_count), FREELIST_DEPTH);
        chk("t5_reissue", 32'(fl_if.alloc_tag[0]), 38);
        model_step();

`ifdef FREELIST_DUP_CHECK_EN
        do_reset();
        s_req = 12'h001;
        apply();
        chk("t6_dup_rst", 32'(fl_if.dup_err), 0);
        model_step();
        idle_stim();
        s_cv = 12'h001; s_cd = 12'h001; s_tag[0] = 40;
        run_step();
        idle_stim();
        apply();
        chk("t6_dup_pulse", 32'(fl_if.dup_err), 1);
        model_step();
        apply();
        chk("t6_dup_clear", 32'(fl_if.dup_err), 0);
        model_step();
`endif

        // Random traffic; many laps of the 352-entry ring exercise pointer wrap.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            phase = (c / 150) % 3;
            cprob = (phase == 0) ? 25 : (phase == 1) ? 80 : 50;
            idle_stim();
            s_req = ($urandom_range(0, 3) == 0) ? '1 : ALLOC_W'($urandom);
            budget = inflight;
            for (int i = 0; i < FREE_W; i++) begin
                s_cv[i]  = ($urandom_range(0, 99) < cprob);
                s_cd[i]  = ($urandom_range(0, 7) != 0);
                s_tag[i] = $urandom_range(0, NUM_PHYS - 1);
                if (s_cv[i] && s_cd[i]) begin
                    if (budget > 0) budget--;
                    else s_cd[i] = 1'b0;
                end
            end
            s_flush = ($urandom_range(0, 39) == 0);
            run_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
